mdu_stall_ctrl: RTL and testbench

//  Sequences the multi-cycle multiply/divide unit (MDU) in EXE and produces the pipeline stall/bubble controls it needs.

---
 rtl/mdu_stall_ctrl.sv | 136 +++++++++++++
 tb/tb_mdu_stall_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mdu_stall_ctrl.sv
// Sequences the multi-cycle multiply/divide unit in EXE and generates the
// PC/ID/EXE hold and MEM bubble controls for the duration of an operation.
module mdu_stall_ctrl #(
  parameter int unsigned DIV_CYCLES = 34,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic EXE_Valid,
  input  logic EXE_IsDiv,
  input  logic EXE_IsMul,
  input  logic EXE_Signed,
  input  logic EXE_Flush,
  input  logic MEM_Stall,
  output logic MDU_Start,
  output logic MDU_Cancel,
  output logic MDU_IsDiv,
  output logic MDU_Signed,
  output logic MDU_ResultValid,
  output logic MDU_PCWr,
  output logic MDU_IDWr,
  output logic MDU_EXEWr,
  output logic MDU_MEMFlush,
  output logic MDU_Busy
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             op_div, op_div_nxt;
  logic             op_signed, op_signed_nxt;
  logic             req;
  logic             stall;

  assign req = EXE_Valid & (EXE_IsDiv | EXE_IsMul) & ~EXE_Flush;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      op_div    <= op_div_nxt;
      op_signed <= op_signed_nxt;
    end
  end

  // Next state and outputs; flush overrides everything, reset forces idle outputs
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    op_div_nxt      = op_div;
    op_signed_nxt   = op_signed;
    stall           = 1'b0;
    MDU_Start       = 1'b0;
    MDU_Cancel      = 1'b0;
    MDU_IsDiv       = 1'b0;
    MDU_Signed      = 1'b0;
    MDU_ResultValid = 1'b0;
    MDU_Busy        = (state != IDLE);

    case (state)
      IDLE: begin
        if (req) begin
          MDU_Start     = 1'b1;
          MDU_IsDiv     = EXE_IsDiv;
          MDU_Signed    = EXE_Signed;
          op_div_nxt    = EXE_IsDiv;
          op_signed_nxt = EXE_Signed;
          cnt_nxt       = EXE_IsDiv ? DIV_LAST : MUL_LAST;
          stall         = 1'b1;
          state_nxt     = RUN;
        end
      end
      RUN: begin
        MDU_IsDiv  = op_div;
        MDU_Signed = op_signed;
        if (EXE_Flush) begin
          MDU_Cancel = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = IDLE;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
          stall   = 1'b1;
        end else begin
          MDU_ResultValid = 1'b1;
          state_nxt       = MEM_Stall ? HOLD : IDLE;
        end
      end
      HOLD: begin
        MDU_IsDiv  = op_div;
        MDU_Signed = op_signed;
        if (EXE_Flush) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          MDU_ResultValid = 1'b1;
          if (!MEM_Stall) state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase

    if (rst) begin
      stall           = 1'b0;
      MDU_Start       = 1'b0;
      MDU_Cancel      = 1'b0;
      MDU_IsDiv       = 1'b0;
      MDU_Signed      = 1'b0;
      MDU_ResultValid = 1'b0;
      MDU_Busy        = 1'b0;
    end

    MDU_PCWr     = ~stall;
    MDU_IDWr     = ~stall;
    MDU_EXEWr    = ~stall;
    MDU_MEMFlush = stall;
  end

endmodule

// File: tb/tb_mdu_stall_ctrl.sv
// Scoreboarded random/directed bench for mdu_stall_ctrl against a cycle-age
// reference model of an MDU operation.
module tb_mdu_stall_ctrl;

  localparam int DIV_N = 34;
  localparam int MUL_N = 2;

  logic clk = 1'b0;
  logic rst, exe_valid, exe_is_div, exe_is_mul, exe_signed, exe_flush, mem_stall;
  logic mdu_start, mdu_cancel, mdu_is_div, mdu_signed, mdu_result_valid;
  logic mdu_pc_wr, mdu_id_wr, mdu_exe_wr, mdu_mem_flush, mdu_busy;

  always #5 clk = ~clk;

  mdu_stall_ctrl #(.DIV_CYCLES(DIV_N), .MUL_CYCLES(MUL_N), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .EXE_Valid(exe_valid), .EXE_IsDiv(exe_is_div), .EXE_IsMul(exe_is_mul),
    .EXE_Signed(exe_signed), .EXE_Flush(exe_flush), .MEM_Stall(mem_stall),
    .MDU_Start(mdu_start), .MDU_Cancel(mdu_cancel), .MDU_IsDiv(mdu_is_div),
    .MDU_Signed(mdu_signed), .MDU_ResultValid(mdu_result_valid),
    .MDU_PCWr(mdu_pc_wr), .MDU_IDWr(mdu_id_wr), .MDU_EXEWr(mdu_exe_wr),
    .MDU_MEMFlush(mdu_mem_flush), .MDU_Busy(mdu_busy)
  );

  // {start,cancel,isdiv,signed,rv,pcwr,idwr,exewr,memflush,busy}
  logic [9:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc_no = 0;

  // Reference model: an operation is tracked by its age (cycles since start)
  bit m_busy = 0;
  int m_age  = 0;
  int m_lat  = 0;
  bit m_div  = 0;
  bit m_sgn  = 0;

  function automatic logic [9:0] pack(bit st, bit cn, bit dv, bit sg, bit rv, bit stl, bit bz);
    return {st, cn, dv, sg, rv, ~stl, ~stl, ~stl, stl, bz};
  endfunction

  task automatic cyc(input bit r, input bit v, input bit d, input bit m,
                     input bit s, input bit f, input bit ms);
    bit req;
    logic [9:0] e;
    @(posedge clk);
    #1;
    rst = r; exe_valid = v; exe_is_div = d; exe_is_mul = m;
    exe_signed = s; exe_flush = f; mem_stall = ms;
    req = v && (d || m) && !f;
    if (r) begin
      e = pack(0, 0, 0, 0, 0, 0, 0);
      m_busy = 0;
    end else if (!m_busy) begin
      if (req) begin
        e = pack(1, 0, d, s, 0, 1, 0);
        m_busy = 1; m_age = 1; m_lat = d ? DIV_N : MUL_N; m_div = d; m_sgn = s;
      end else begin
        e = pack(0, 0, 0, 0, 0, 0, 0);
      end
    end else if (f) begin
      e = pack(0, (m_age <= m_lat), m_div, m_sgn, 0, 0, 1);
      m_busy = 0;
    end else if (m_age < m_lat) begin
      e = pack(0, 0, m_div, m_sgn, 0, 1, 1);
      m_age++;
    end else begin
      e = pack(0, 0, m_div, m_sgn, 1, 0, 1);
      if (ms) m_age++;
      else m_busy = 0;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare every presented cycle on the falling edge
  always @(negedge clk) begin
    logic [9:0] act, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {mdu_start, mdu_cancel, mdu_is_div, mdu_signed, mdu_result_valid,
             mdu_pc_wr, mdu_id_wr, mdu_exe_wr, mdu_mem_flush, mdu_busy};
      n_vec++;
      cyc_no++;
      if (act !== e) begin
        n_err++;
        $display("FAIL outs cycle %0d: got %b expected %b (start,cancel,isdiv,signed,rv,pcwr,idwr,exewr,memflush,busy)",
                 cyc_no, act, e);
      end
    end
  end

  initial begin
    rst = 1; exe_valid = 0; exe_is_div = 0; exe_is_mul = 0;
    exe_signed = 0; exe_flush = 0; mem_stall = 0;

    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);

    // DIVU held in EXE through its result cycle
    repeat (DIV_N + 1) cyc(0, 1, 1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);

    // signed MULT
    repeat (MUL_N + 1) cyc(0, 1, 0, 1, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);

    // DIV flushed at T+5
    repeat (5) cyc(0, 1, 1, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 1, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);

    // DIV finishing into three cycles of downstream stall
    for (int i = 0; i < DIV_N + 4; i++)
      cyc(0, 1, 1, 0, 0, 0, (i >= DIV_N && i < DIV_N + 3));
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);

    // two DIVs back-to-back
    repeat (2 * (DIV_N + 1)) cyc(0, 1, 1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);

    // reset mid-run, then a flushed request while idle
    repeat (10) cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);

    // HOLD flushed, and flush on the result cycle
    for (int i = 0; i < MUL_N + 2; i++)
      cyc(0, 1, 0, 1, 0, (i == MUL_N + 1), 1);
    for (int i = 0; i < MUL_N + 1; i++)
      cyc(0, 1, 0, 1, 0, (i == MUL_N), 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 4000; i++)
      cyc(($urandom % 200) == 0, ($urandom % 4) != 0, $urandom % 2, $urandom % 2,
          $urandom % 2, ($urandom % 40) == 0, ($urandom % 4) == 0);

    cyc(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
